// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: mnemonic codes, opcode/funct constants and field positions.
// Used by the program loader's encoder and by the CPU control decode.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    MN_ADD  = 5'd0,
    MN_ADDU = 5'd1,
    MN_SUB  = 5'd2,
    MN_SUBU = 5'd3,
    MN_AND  = 5'd4,
    MN_OR   = 5'd5,
    MN_SLT  = 5'd6,
    MN_SLTU = 5'd7,
    MN_SLL  = 5'd8,
    MN_ADDI = 5'd9,
    MN_ORI  = 5'd10,
    MN_LW   = 5'd11,
    MN_SW   = 5'd12,
    MN_BEQ  = 5'd13,
    MN_J    = 5'd14,
    MN_JAL  = 5'd15
  } mnem_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // Non-R-type mnemonics return 0; the caller only uses this for R-type codes.
  function automatic logic [5:0] funct_of(input logic [4:0] code);
    logic [5:0] fn;
    fn = 6'h00;
    case (code)
      MN_ADD:  fn = FN_ADD;
      MN_ADDU: fn = FN_ADDU;
      MN_SUB:  fn = FN_SUB;
      MN_SUBU: fn = FN_SUBU;
      MN_AND:  fn = FN_AND;
      MN_OR:   fn = FN_OR;
      MN_SLT:  fn = FN_SLT;
      MN_SLTU: fn = FN_SLTU;
      MN_SLL:  fn = FN_SLL;
      default: fn = 6'h00;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/mips_instr_encoder.sv
// Combinational symbolic-fields to 32-bit MIPS word encoder with illegal/range flags.
// Define ENC_RANGE_CHECK_EN to flag out-of-range fields instead of silently truncating them.
module mips_instr_encoder
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (mnem)
      MN_ADD, MN_ADDU, MN_SUB, MN_SUBU, MN_AND, MN_OR, MN_SLT, MN_SLTU: begin
        word[OP_LSB +: 6] = OP_RTYPE;
        word[RS_LSB +: 5] = rs;
        word[RT_LSB +: 5] = rt;
        word[RD_LSB +: 5] = rd;
        word[5:0]         = funct_of(mnem);
      end
      // SLL has no rs operand, so rs is forced to zero in the encoding.
      MN_SLL: begin
        word[OP_LSB +: 6] = OP_RTYPE;
        word[RT_LSB +: 5] = rt;
        word[RD_LSB +: 5] = rd;
        word[SH_LSB +: 5] = shamt;
        word[5:0]         = FN_SLL;
      end
      MN_ADDI, MN_ORI, MN_LW, MN_SW, MN_BEQ: begin
        case (mnem)
          MN_ADDI: word[OP_LSB +: 6] = OP_ADDI;
          MN_ORI:  word[OP_LSB +: 6] = OP_ORI;
          MN_LW:   word[OP_LSB +: 6] = OP_LW;
          MN_SW:   word[OP_LSB +: 6] = OP_SW;
          default: word[OP_LSB +: 6] = OP_BEQ;
        endcase
        word[RS_LSB +: 5] = rs;
        word[RT_LSB +: 5] = rt;
        word[15:0]        = imm[15:0];
      end
      MN_J, MN_JAL: begin
        word[OP_LSB +: 6] = (mnem == MN_J) ? OP_J : OP_JAL;
        word[25:0]        = imm;
      end
      default: illegal = 1'b1;
    endcase

`ifdef ENC_RANGE_CHECK_EN
    // ORI zero-extends, so only a clean zero upper half is acceptable there.
    if (!illegal) begin
      if ((mnem != MN_SLL) && (shamt != 5'd0))
        range_err = 1'b1;
      if ((mnem inside {MN_ADDI, MN_LW, MN_SW, MN_BEQ}) &&
          (imm[25:16] != 10'd0) && (imm[25:16] != {10{imm[15]}}))
        range_err = 1'b1;
      if ((mnem == MN_ORI) && (imm[25:16] != 10'd0))
        range_err = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/imem_enc_loader.sv
// Streams symbolic instructions in, encodes them and writes them sequentially into instruction memory.
// Field range checking is enabled by defining ENC_RANGE_CHECK_EN (see mips_instr_encoder).
module imem_enc_loader
  import mips_isa_pkg::*;
#(
  parameter int AW   = 5,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_mnem,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [25:0]   in_imm,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          full,
  output logic          err_illegal,
  output logic          err_range
);

  localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  load_state_e   state;
  logic [AW-1:0] ptr;
  logic          pending_last;
  logic          ptr_end;
  logic [31:0]   enc_word;
  logic          enc_illegal;
  logic          enc_range;
  logic          xfer;

  mips_instr_encoder u_encoder (
    .mnem      (in_mnem),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .shamt     (in_shamt),
    .imm       (in_imm),
    .word      (enc_word),
    .illegal   (enc_illegal),
    .range_err (enc_range)
  );

  // ptr_end stands in for the pointer stepping past the top word, so the address never wraps.
  assign in_ready = (state == ST_LOAD) && !pending_last && !ptr_end;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= BASE_ADDR;
      pending_last <= 1'b0;
      ptr_end      <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= BASE_ADDR;
      im_wdata     <= '0;
      count        <= '0;
      done         <= 1'b0;
      full         <= 1'b0;
      err_illegal  <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
        state        <= ST_LOAD;
        ptr          <= BASE_ADDR;
        pending_last <= 1'b0;
        ptr_end      <= 1'b0;
        count        <= '0;
        done         <= 1'b0;
        full         <= 1'b0;
        err_illegal  <= 1'b0;
        err_range    <= 1'b0;
      end else if (state == ST_LOAD) begin
        // The final word is already strobing this cycle; finish one cycle after it.
        if (pending_last || ptr_end) begin
          state <= ST_DONE;
          done  <= 1'b1;
          full  <= ptr_end;
        end else if (xfer) begin
          if (in_last)
            pending_last <= 1'b1;
          if (enc_illegal) begin
            err_illegal <= 1'b1;
          end else if (enc_range) begin
            err_range <= 1'b1;
          end else begin
            im_we    <= 1'b1;
            im_addr  <= ptr;
            im_wdata <= enc_word;
            count    <= count + (AW+1)'(1);
            if (ptr == LAST_ADDR)
              ptr_end <= 1'b1;
            else
              ptr <= ptr + AW'(1);
          end
        end
      end
    end
  end

endmodule
